// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHK state and trailer byte).
package loader_pkg;

    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [7:0] CHK_INIT = 8'h00;

    // States in which the loader is willing to take a byte from the host link.
    function automatic logic is_rx_state(input state_t s);
        return (s == CNT_HI) || (s == CNT_LO) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master: host/byte source side; slave: loader side.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_wr_en;
    logic [ADDR_W-1:0] im_wr_adr;
    logic [31:0]       im_wr_data;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  im_wr_en,
        input  im_wr_adr,
        input  im_wr_data
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output im_wr_en,
        output im_wr_adr,
        output im_wr_data
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Big-endian word assembler: shifts in bytes MSB first and flags the byte
// that completes a word. The completed word is presented combinationally so
// the top level can register it on the same edge that accepts the last byte.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        RESET,
    input  logic [7:0]  i_byte,
    input  logic        i_valid,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam int SH_W  = 8 * (BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [SH_W-1:0]  r_shift;

    // Shift each accepted byte in; the counter wraps naturally after the last byte.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_valid) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_shift <= {r_shift[SH_W-9:0], i_byte};
        end
    end

    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_valid && (r_cnt == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses COUNT_HI, COUNT_LO, then N
// big-endian words, writes them to addresses 0..N-1 and holds the CPU in
// reset until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR trailer byte, CHK state).
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
)
(
    input  logic          clk,
    input  logic          RESET,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          error,
    output logic [ADDR_W:0] words_loaded
);

    localparam int CNT_W = 8 * HDR_BYTES;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W:0] DEPTH_CMP = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W:0] ONE       = (CNT_W + 1)'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_count_hi;
    logic [CNT_W-1:0]  r_count;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_adr;
    logic [31:0]       r_wr_data;
    logic [ADDR_W:0]   r_words;
    logic              r_cpu_reset;

    logic              w_rx_ready;
    logic              w_accept;
    logic [CNT_W-1:0]  w_n;
    logic              w_n_too_big;
    logic              w_last_word;
    logic              w_byte_in;
    logic [31:0]       w_word;
    logic              w_word_valid;

    assign w_rx_ready  = is_rx_state(r_state) && !RESET;
    assign w_accept    = bus.rx_valid && w_rx_ready;
    assign w_n         = {r_count_hi, bus.rx_data};
    assign w_n_too_big = {1'b0, w_n} > DEPTH_CMP;
    assign w_last_word = ((CNT_W + 1)'(r_words) + ONE) == {1'b0, r_count};
    assign w_byte_in   = w_accept && (r_state == DATA);

    word_assembler u_asm (
        .clk          (clk),
        .RESET        (RESET),
        .i_byte       (bus.rx_data),
        .i_valid      (w_byte_in),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_chk;

    // Running XOR of every accepted byte; the trailer is compared before it is folded in.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_chk <= CHK_INIT;
        end else if (w_accept) begin
            r_chk <= r_chk ^ bus.rx_data;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= CNT_HI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; the image end goes to CHK only when the trailer exists.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CNT_HI: begin
                if (w_accept) w_state_nxt = CNT_LO;
            end
            CNT_LO: begin
                if (w_accept) begin
                    if (w_n_too_big) begin
                        w_state_nxt = ERR;
                    end else if (w_n == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        w_state_nxt = CHK;
`else
                        w_state_nxt = DONE;
`endif
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (w_word_valid && w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_nxt = CHK;
`else
                    w_state_nxt = DONE;
`endif
                end
            end
            CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (w_accept) begin
                    w_state_nxt = (bus.rx_data == r_chk) ? DONE : ERR;
                end
`else
                w_state_nxt = ERR;
`endif
            end
            DONE:    w_state_nxt = DONE;
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = CNT_HI;
        endcase
    end

    // Header capture, registered write port, word counter and CPU reset release.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_count_hi  <= '0;
            r_count     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_adr    <= '0;
            r_wr_data   <= '0;
            r_words     <= '0;
            r_cpu_reset <= 1'b1;
        end else begin
            r_wr_en     <= w_word_valid;
            r_cpu_reset <= (r_state != DONE);
            if (w_accept && (r_state == CNT_HI)) begin
                r_count_hi <= bus.rx_data;
            end
            if (w_accept && (r_state == CNT_LO)) begin
                r_count <= w_n;
            end
            if (w_word_valid) begin
                r_wr_adr  <= r_words[ADDR_W-1:0];
                r_wr_data <= w_word;
                r_words   <= r_words + (ADDR_W + 1)'(1);
            end
        end
    end

    assign bus.rx_ready   = w_rx_ready;
    assign bus.im_wr_en   = r_wr_en;
    assign bus.im_wr_adr  = r_wr_adr;
    assign bus.im_wr_data = r_wr_data;
    assign cpu_reset      = r_cpu_reset;
    assign done           = (r_state == DONE);
    assign error          = (r_state == ERR);
    assign words_loaded   = r_words;

endmodule
